// File: rtl/display_sequencer.sv
// Display mode sequencer: debounces the "next" push-button, optionally
// auto-advances every DWELL_TICKS slow ticks, and drives the shifter
// direction and shift/flash mux selects from a three-state mode FSM.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_SHL   | shifter running left  (mode 0, shift 0, func 0)
// ST_SHR   | shifter running right (mode 1, shift 1, func 0)
// ST_FLASH | flasher selected      (mode 2, shift 0, func 1)
module display_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DWELL_TICKS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic       shift_sel,
  output logic       func_sel,
  output logic [1:0] mode,
  output logic       mode_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SHL   = 2'd0,
    ST_SHR   = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dwell;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_shift_sel;
  logic          r_func_sel;
  logic          r_mode_changed;
  logic          w_shift_nxt;
  logic          w_func_nxt;
  logic          w_deb_accept;
  logic          w_press;
  logic          w_dwell_expire;
  logic          w_advance;

  // The accepted level flips on the edge the counter would reach its
  // terminal value; a rising flip is the press event on that same edge.
  assign w_deb_accept   = (r_s2 != r_deb) && (r_cnt == CNT_LAST);
  assign w_press        = w_deb_accept && r_s2;
  assign w_dwell_expire = auto_en && tick && (r_dwell == DWELL_LAST);
  assign w_advance      = w_press || w_dwell_expire;

  // Two-flop synchroniser followed by the debounce counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= btn_next;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_deb_accept) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Dwell counter: held at zero while auto-cycling is off, restarted by any advance.
  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      r_dwell <= '0;
    end else if (w_advance) begin
      r_dwell <= '0;
    end else if (tick) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // State register; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_SHL;
      r_shift_sel    <= 1'b0;
      r_func_sel     <= 1'b0;
      r_mode_changed <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_shift_sel    <= w_shift_nxt;
      r_func_sel     <= w_func_nxt;
      r_mode_changed <= w_advance;
    end
  end

  // Next state: one step per advance, wrapping FLASH back to SHL.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SHL:   if (w_advance) w_state_nxt = ST_SHR;
      ST_SHR:   if (w_advance) w_state_nxt = ST_FLASH;
      ST_FLASH: if (w_advance) w_state_nxt = ST_SHL;
      default:  w_state_nxt = ST_SHL;
    endcase
  end

  // Output decode of the upcoming state, so the registered selects match it.
  always_comb begin
    w_shift_nxt = 1'b0;
    w_func_nxt  = 1'b0;
    case (w_state_nxt)
      ST_SHR:   w_shift_nxt = 1'b1;
      ST_FLASH: w_func_nxt  = 1'b1;
      default:  ;
    endcase
  end

  assign mode         = r_state;
  assign shift_sel    = r_shift_sel;
  assign func_sel     = r_func_sel;
  assign mode_changed = r_mode_changed;

endmodule
